// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer with prioritized redirects (br > jr > eret > irq > j) feeding a prefetch FIFO to decode.
// Latency: an instruction fetched in cycle N is presented on id_* in cycle N+1; a redirect empties id_* for one cycle.
// Backpressure: id_ready low holds the FIFO head; when the FIFO is full and nothing pops, pc holds and no fetch occurs.
// Ports: clk/rst_n (synchronous, active-low); imem_addr/imem_rdata combinational ROM port;
//   id_valid/id_ready/id_instr/id_pc_plus4 decode handoff; br_*/jr_*/j_* redirect requests;
//   irq/eret/epc/in_irq interrupt entry and return; halted/halt_count jump-to-self halt detection.
module pc_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_AW    = 10,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] INT_VECTOR = 32'h0000_0100,
  parameter int              HALT_HOLD  = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [IMEM_AW-1:0]               imem_addr,
  input  logic [XLEN-1:0]                  imem_rdata,
  input  logic                             id_ready,
  output logic                             id_valid,
  output logic [XLEN-1:0]                  id_instr,
  output logic [XLEN-1:0]                  id_pc_plus4,
  input  logic                             br_valid,
  input  logic [XLEN-1:0]                  br_target,
  input  logic                             jr_valid,
  input  logic [XLEN-1:0]                  jr_target,
  input  logic                             j_valid,
  input  logic [XLEN-1:0]                  j_target,
  input  logic [XLEN-1:0]                  j_src_pc,
  input  logic                             irq,
  input  logic                             eret,
  output logic [XLEN-1:0]                  epc,
  output logic                             in_irq,
  output logic                             halted,
  output logic [$clog2(HALT_HOLD+1)-1:0]   halt_count
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam int                HCW      = $clog2(HALT_HOLD + 1);
  localparam logic [AW:0]       FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [HCW-1:0]    HALT_MAX = HALT_HOLD[HCW-1:0];

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;

  // Prefetch buffer: each entry is {instruction, pc+4 of that instruction}.
  logic [2*XLEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [2*XLEN-1:0] head;
  logic              empty;
  logic              full;

  logic              pop;
  logic              push;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              take_irq;
  logic              take_eret;
  logic              self_jump;

  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc[IMEM_AW+1:2];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  assign id_valid    = !empty;
  assign id_instr    = empty ? '0 : head[2*XLEN-1:XLEN];
  assign id_pc_plus4 = empty ? '0 : head[XLEN-1:0];

  assign halted = (halt_count == HALT_MAX);
  assign pop    = id_valid && id_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still streams at one per cycle.
  assign push   = !halted && !redirect && (!full || pop);

  // Redirect arbitration; everything is frozen once halted.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc;
    take_irq    = 1'b0;
    take_eret   = 1'b0;
    self_jump   = 1'b0;
    if (!halted) begin
      if (br_valid) begin
        redirect    = 1'b1;
        redirect_pc = br_target;
      end else if (jr_valid) begin
        redirect    = 1'b1;
        redirect_pc = jr_target;
      end else if (eret && in_irq) begin
        redirect    = 1'b1;
        redirect_pc = epc;
        take_eret   = 1'b1;
      end else if (irq && !in_irq) begin
        redirect    = 1'b1;
        redirect_pc = INT_VECTOR;
        take_irq    = 1'b1;
      end else if (j_valid) begin
        redirect    = 1'b1;
        redirect_pc = j_target;
        self_jump   = (j_target == j_src_pc);
      end
    end
  end

  // Payload storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {imem_rdata, pc_plus4};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      // Flush wins over a same-cycle pop; the popped head was still delivered.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      epc        <= '0;
      in_irq     <= 1'b0;
      halt_count <= '0;
    end else begin
      if (redirect)  pc <= redirect_pc;
      else if (push) pc <= pc_plus4;

      // Return to the oldest not-yet-decoded instruction, or to the next fetch if none is buffered.
      if (take_irq) begin
        epc    <= empty ? pc : (head[XLEN-1:0] - XLEN'(4));
        in_irq <= 1'b1;
      end
      if (take_eret) in_irq <= 1'b0;

      if (self_jump && (halt_count != HALT_MAX)) halt_count <= halt_count + HCW'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;
  localparam int HOLD  = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        j_valid;
  logic [31:0] j_target;
  logic [31:0] j_src_pc;
  logic        irq;
  logic        eret;
  logic [31:0] epc;
  logic        in_irq;
  logic        halted;
  logic [2:0]  halt_count;

  // ROM word n holds the value n.
  assign imem_rdata = {22'd0, imem_addr};

  pc_fetch_unit #(
    .XLEN(32), .IMEM_AW(10), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0),
    .INT_VECTOR(32'h0000_0100), .HALT_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .br_valid(br_valid), .br_target(br_target), .jr_valid(jr_valid), .jr_target(jr_target),
    .j_valid(j_valid), .j_target(j_target), .j_src_pc(j_src_pc),
    .irq(irq), .eret(eret), .epc(epc), .in_irq(in_irq), .halted(halted), .halt_count(halt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural pc, buffered instructions as queues, interrupt and halt state.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_in_irq;
  int          m_hc;
  bit          m_live = 1'b0;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc4[$];

  task automatic model_check();
    if (!m_live) return;
    chk("id_valid",    32'(id_valid), 32'(q_pc4.size() != 0));
    chk("id_instr",    id_instr,     (q_instr.size() != 0) ? q_instr[0] : 32'd0);
    chk("id_pc_plus4", id_pc_plus4,  (q_pc4.size() != 0) ? q_pc4[0] : 32'd0);
    chk("imem_addr",   32'(imem_addr), (m_pc >> 2) & 32'h3ff);
    chk("epc",         epc,          m_epc);
    chk("in_irq",      32'(in_irq),  32'(m_in_irq));
    chk("halt_count",  32'(halt_count), 32'(m_hc));
    chk("halted",      32'(halted),  32'(m_hc == HOLD));
  endtask

  task automatic flush_to(input logic [31:0] target);
    q_instr.delete();
    q_pc4.delete();
    m_pc = target;
  endtask

  task automatic model_step();
    bit          pop;
    logic [31:0] head_pc;
    if (!rst_n) begin
      m_live = 1'b1;
      m_pc = 32'h0; m_epc = 32'h0; m_in_irq = 1'b0; m_hc = 0;
      q_instr.delete();
      q_pc4.delete();
      return;
    end
    if (!m_live) return;
    pop     = (q_pc4.size() != 0) && id_ready;
    head_pc = (q_pc4.size() != 0) ? q_pc4[0] - 32'd4 : m_pc;
    if (pop) begin
      void'(q_instr.pop_front());
      void'(q_pc4.pop_front());
    end
    if (m_hc == HOLD) return;
    if (br_valid)                 flush_to(br_target);
    else if (jr_valid)            flush_to(jr_target);
    else if (eret && m_in_irq)    begin flush_to(m_epc); m_in_irq = 1'b0; end
    else if (irq && !m_in_irq)    begin m_epc = head_pc; flush_to(32'h100); m_in_irq = 1'b1; end
    else if (j_valid) begin
      if (j_target == j_src_pc && m_hc < HOLD) m_hc++;
      flush_to(j_target);
    end else if (q_pc4.size() < DEPTH) begin
      q_instr.push_back({22'd0, m_pc[11:2]});
      q_pc4.push_back(m_pc + 32'd4);
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Inputs are set just after a falling edge; one call = one rising edge.
  task automatic cyc();
    #1;
    model_check();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    br_valid = 0; jr_valid = 0; j_valid = 0; irq = 0; eret = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b0;
    br_target = 0; jr_target = 0; j_target = 0; j_src_pc = 0;
    idle();
    @(negedge clk);

    // Streaming fetch: valid on the second cycle, instructions 0,1,2...
    do_reset();
    id_ready = 1'b1;
    #1;
    chk("t1_rst_valid", 32'(id_valid), 32'd0);
    chk("t1_rst_instr", id_instr, 32'd0);
    cyc();
    chk("t1_first_instr", id_instr, 32'd0);
    chk("t1_first_pc4", id_pc_plus4, 32'd4);
    cyc();
    chk("t1_second_instr", id_instr, 32'd1);
    chk("t1_second_pc4", id_pc_plus4, 32'd8);
    repeat (8) cyc();

    // Stall: exactly DEPTH pushes, pc frozen at 0x10, then no gaps or duplicates.
    do_reset();
    id_ready = 1'b0;
    repeat (8) cyc();
    chk("t2_pc_frozen", 32'(imem_addr), 32'd4);
    chk("t2_head_held", id_instr, 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_drain_order", id_instr, 32'(i));
      cyc();
    end

    // Branch beats jump in the same cycle; pc wraps past the top of the address space.
    do_reset();
    id_ready = 1'b1;
    repeat (8) cyc();
    chk("t3_pc_at_20", 32'(imem_addr), 32'd8);
    br_valid = 1; br_target = 32'h80; j_valid = 1; j_target = 32'h40; j_src_pc = 32'h1c;
    cyc();
    idle();
    chk("t3_flush_valid", 32'(id_valid), 32'd0);
    chk("t3_redirect_addr", 32'(imem_addr), 32'h20);
    cyc();
    chk("t3_br_instr", id_instr, 32'h20);
    chk("t3_br_pc4", id_pc_plus4, 32'h84);
    br_valid = 1; br_target = 32'hffff_fffc;
    cyc();
    idle();
    cyc();
    chk("t3_wrap_instr", id_instr, 32'h3ff);
    chk("t3_wrap_pc4", id_pc_plus4, 32'h0);
    chk("t3_wrap_addr", 32'(imem_addr), 32'h0);

    // Interrupt entry with head pc 0x14, no nesting, return, re-entry when irq still high.
    do_reset();
    id_ready = 1'b1;
    repeat (6) cyc();
    chk("t4_head_pc4", id_pc_plus4, 32'h18);
    id_ready = 1'b0; irq = 1;
    cyc();
    chk("t4_epc", epc, 32'h14);
    chk("t4_in_irq", 32'(in_irq), 32'd1);
    chk("t4_vector_addr", 32'(imem_addr), 32'h40);
    cyc();
    chk("t4_no_nest_addr", 32'(imem_addr), 32'h41);
    chk("t4_no_nest_epc", epc, 32'h14);
    eret = 1;
    cyc();
    eret = 0;
    chk("t4_eret_in_irq", 32'(in_irq), 32'd0);
    chk("t4_eret_addr", 32'(imem_addr), 32'h5);
    cyc();
    chk("t4_reenter", 32'(in_irq), 32'd1);
    chk("t4_reenter_epc", epc, 32'h14);
    idle(); eret = 1;
    cyc();
    idle();
    id_ready = 1'b1;
    repeat (3) cyc();

    // Halt: a losing self-jump does not count; five winning ones halt, then everything freezes.
    do_reset();
    id_ready = 1'b1;
    j_valid = 1; j_target = 32'h30; j_src_pc = 32'h30; br_valid = 1; br_target = 32'h30;
    cyc();
    br_valid = 0;
    chk("t5_losing_j", 32'(halt_count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t5_halt_count", 32'(halt_count), 32'(k));
      chk("t5_halted", 32'(halted), 32'(k == 5));
    end
    j_valid = 0; br_valid = 1; br_target = 32'h80;
    cyc();
    idle();
    chk("t5_br_ignored", 32'(imem_addr), 32'h0c);
    repeat (3) cyc();
    chk("t5_no_fetch", 32'(id_valid), 32'd0);
    chk("t5_pc_frozen", 32'(imem_addr), 32'h0c);

    // Reset mid-operation with a full FIFO and an active interrupt.
    do_reset();
    id_ready = 1'b1;
    repeat (3) cyc();
    id_ready = 1'b0; irq = 1;
    cyc();
    irq = 0;
    repeat (5) cyc();
    chk("t6_pre_in_irq", 32'(in_irq), 32'd1);
    chk("t6_pre_full_addr", 32'(imem_addr), 32'h44);
    chk("t6_pre_epc", epc, 32'h8);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_valid", 32'(id_valid), 32'd0);
    chk("t6_instr", id_instr, 32'd0);
    chk("t6_pc", 32'(imem_addr), 32'd0);
    chk("t6_epc", epc, 32'd0);
    chk("t6_in_irq", 32'(in_irq), 32'd0);
    chk("t6_halt_count", 32'(halt_count), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      id_ready  = ($urandom_range(0, 3) != 0);
      br_valid  = ($urandom_range(0, 19) == 0);
      jr_valid  = ($urandom_range(0, 19) == 0);
      j_valid   = ($urandom_range(0, 9) == 0);
      irq       = ($urandom_range(0, 14) == 0);
      eret      = ($urandom_range(0, 9) == 0);
      br_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      jr_target = ($urandom_range(0, 7) == 0) ? $urandom() : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      j_target  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      j_src_pc  = ($urandom_range(0, 2) == 0) ? j_target : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cyc();
    end
    idle();
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
